// File: rtl/feature_pingpong_ctrl.sv
// ---------------------------------------------------------------------------
// feature_pingpong_ctrl
//
// Write-side scheduler for a double-buffered feature memory.
// A job descriptor (words per tile, number of tiles) is accepted when idle.
// Incoming feature words are streamed into whichever bank is free. Each
// filled bank is handed to compute with a one-cycle start pulse, and it is
// reclaimed on the compute side's done pulse. Filling one bank therefore
// overlaps computation on the other.
//
// Ports
//   clk, rst            : clock and asynchronous active-low reset
//   cfg_valid/ready     : job descriptor handshake
//   cfg_tile_words      : words per tile (1..2^ADDR_WIDTH-1)
//   cfg_num_tiles       : tiles in the job (1..255)
//   in_valid/ready/data : input feature word stream
//   fetcher_to_mem      : registered write enable toward the bank demux
//   wr_feature_addr     : registered write word address
//   wr_feature_data     : registered write data
//   wr_feature_sel      : registered bank select (0 = bank0, 1 = bank1)
//   comp_start          : one-cycle pulse, bank comp_bank handed to compute
//   comp_bank           : bank currently owned by compute
//   comp_done           : one-cycle pulse, compute releases comp_bank
//   bank_full           : per-bank full flags
//   job_done            : one-cycle pulse when the last tile is released
// ---------------------------------------------------------------------------
module feature_pingpong_ctrl #(
   parameter int FEATURE_WIDTH = 16,
   parameter int ADDR_WIDTH    = 15
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       cfg_valid,
   output logic                       cfg_ready,
   input  logic [ADDR_WIDTH-1:0]      cfg_tile_words,
   input  logic [7:0]                 cfg_num_tiles,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [2*FEATURE_WIDTH-1:0] in_data,
   output logic                       fetcher_to_mem,
   output logic [ADDR_WIDTH-1:0]      wr_feature_addr,
   output logic [2*FEATURE_WIDTH-1:0] wr_feature_data,
   output logic                       wr_feature_sel,
   output logic                       comp_start,
   output logic                       comp_bank,
   input  logic                       comp_done,
   output logic [1:0]                 bank_full,
   output logic                       job_done
);

   typedef enum logic [1:0] {W_IDLE, W_FILL, W_WAIT, W_DRAIN} w_state_t;
   typedef enum logic       {R_IDLE, R_RUN}                   r_state_t;

   w_state_t                   w_state_q, w_state_d;
   r_state_t                   r_state_q, r_state_d;
   logic [ADDR_WIDTH-1:0]      tile_words_q, tile_words_d;
   logic [7:0]                 num_tiles_q, num_tiles_d;
   logic [ADDR_WIDTH-1:0]      wcnt_q, wcnt_d;
   logic [7:0]                 tiles_written_q, tiles_written_d;
   logic [7:0]                 tiles_read_q, tiles_read_d;
   logic                       wr_bank_q, wr_bank_d;
   logic                       rd_bank_q, rd_bank_d;
   logic [1:0]                 bank_full_q, bank_full_d;
   logic                       fetcher_to_mem_q, fetcher_to_mem_d;
   logic [ADDR_WIDTH-1:0]      wr_addr_q, wr_addr_d;
   logic [2*FEATURE_WIDTH-1:0] wr_data_q, wr_data_d;
   logic                       wr_sel_q, wr_sel_d;
   logic                       comp_start_q, comp_start_d;
   logic                       comp_bank_q, comp_bank_d;
   logic                       job_done_q, job_done_d;

   logic cfg_accept;
   logic wr_hs;
   logic last_word;
   logic rd_release;
   logic last_release;
   logic nxt_bank;

   // ready signals are pure decodes of the registered write state
   assign cfg_ready = (w_state_q == W_IDLE);
   assign in_ready  = (w_state_q == W_FILL);

   assign cfg_accept   = cfg_valid && (w_state_q == W_IDLE) &&
                         (cfg_tile_words != '0) && (cfg_num_tiles != '0);
   assign wr_hs        = in_valid && (w_state_q == W_FILL);
   assign last_word    = wr_hs && (wcnt_q == tile_words_q - ADDR_WIDTH'(1));
   // comp_done only counts while compute actually owns a bank
   assign rd_release   = comp_done && (r_state_q == R_RUN);
   assign last_release = rd_release && (tiles_read_q + 8'd1 == num_tiles_q);
   assign nxt_bank     = ~wr_bank_q;

   // ---- write FSM: next state, counters and write-port register inputs ----
   always_comb begin
      w_state_d        = w_state_q;
      tile_words_d     = tile_words_q;
      num_tiles_d      = num_tiles_q;
      wcnt_d           = wcnt_q;
      tiles_written_d  = tiles_written_q;
      wr_bank_d        = wr_bank_q;
      job_done_d       = 1'b0;
      fetcher_to_mem_d = wr_hs;
      wr_addr_d        = wr_addr_q;
      wr_data_d        = wr_data_q;
      wr_sel_d         = wr_sel_q;

      if (wr_hs) begin
         wr_addr_d = wcnt_q;
         wr_data_d = in_data;
         wr_sel_d  = wr_bank_q;
      end

      case (w_state_q)
         W_IDLE: begin
            // zero-field descriptors are consumed without starting a job
            if (cfg_accept) begin
               tile_words_d    = cfg_tile_words;
               num_tiles_d     = cfg_num_tiles;
               wcnt_d          = '0;
               tiles_written_d = '0;
               w_state_d       = W_FILL;
            end
         end
         W_FILL: begin
            if (wr_hs) begin
               wcnt_d = wcnt_q + ADDR_WIDTH'(1);
               if (last_word) begin
                  wcnt_d          = '0;
                  wr_bank_d       = nxt_bank;
                  tiles_written_d = tiles_written_q + 8'd1;
                  if (tiles_written_q + 8'd1 == num_tiles_q) begin
                     w_state_d = W_DRAIN;
                  end else if (bank_full_q[nxt_bank] &&
                               !(rd_release && (rd_bank_q == nxt_bank))) begin
                     w_state_d = W_WAIT;
                  end
               end
            end
         end
         W_WAIT: begin
            // a release in this very cycle reopens the bank without a bubble
            if (!bank_full_q[wr_bank_q] ||
                (rd_release && (rd_bank_q == wr_bank_q))) begin
               w_state_d = W_FILL;
            end
         end
         W_DRAIN: begin
            if (last_release) begin
               job_done_d = 1'b1;
               w_state_d  = W_IDLE;
            end
         end
         default: w_state_d = W_IDLE;
      endcase
   end

   // ---- read FSM: hands full banks to compute in write order ----
   always_comb begin
      r_state_d    = r_state_q;
      rd_bank_d    = rd_bank_q;
      tiles_read_d = tiles_read_q;
      comp_start_d = 1'b0;
      comp_bank_d  = comp_bank_q;

      case (r_state_q)
         R_IDLE: begin
            if (bank_full_q[rd_bank_q]) begin
               comp_start_d = 1'b1;
               comp_bank_d  = rd_bank_q;
               r_state_d    = R_RUN;
            end
         end
         R_RUN: begin
            if (comp_done) begin
               rd_bank_d    = ~rd_bank_q;
               tiles_read_d = tiles_read_q + 8'd1;
               r_state_d    = R_IDLE;
            end
         end
         default: r_state_d = R_IDLE;
      endcase

      // banks are empty whenever a job is accepted, so this never races a read
      if (cfg_accept) begin
         tiles_read_d = '0;
      end
   end

   // ---- bank ownership flags ----
   // set and clear target different banks, so both may apply together
   always_comb begin
      bank_full_d = bank_full_q;
      if (rd_release) begin
         bank_full_d[rd_bank_q] = 1'b0;
      end
      if (last_word) begin
         bank_full_d[wr_bank_q] = 1'b1;
      end
   end

   // ---- state registers ----
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         w_state_q        <= W_IDLE;
         r_state_q        <= R_IDLE;
         tile_words_q     <= '0;
         num_tiles_q      <= '0;
         wcnt_q           <= '0;
         tiles_written_q  <= '0;
         tiles_read_q     <= '0;
         wr_bank_q        <= 1'b0;
         rd_bank_q        <= 1'b0;
         bank_full_q      <= 2'b00;
         fetcher_to_mem_q <= 1'b0;
         wr_addr_q        <= '0;
         wr_data_q        <= '0;
         wr_sel_q         <= 1'b0;
         comp_start_q     <= 1'b0;
         comp_bank_q      <= 1'b0;
         job_done_q       <= 1'b0;
      end else begin
         w_state_q        <= w_state_d;
         r_state_q        <= r_state_d;
         tile_words_q     <= tile_words_d;
         num_tiles_q      <= num_tiles_d;
         wcnt_q           <= wcnt_d;
         tiles_written_q  <= tiles_written_d;
         tiles_read_q     <= tiles_read_d;
         wr_bank_q        <= wr_bank_d;
         rd_bank_q        <= rd_bank_d;
         bank_full_q      <= bank_full_d;
         fetcher_to_mem_q <= fetcher_to_mem_d;
         wr_addr_q        <= wr_addr_d;
         wr_data_q        <= wr_data_d;
         wr_sel_q         <= wr_sel_d;
         comp_start_q     <= comp_start_d;
         comp_bank_q      <= comp_bank_d;
         job_done_q       <= job_done_d;
      end
   end

   assign fetcher_to_mem  = fetcher_to_mem_q;
   assign wr_feature_addr = wr_addr_q;
   assign wr_feature_data = wr_data_q;
   assign wr_feature_sel  = wr_sel_q;
   assign comp_start      = comp_start_q;
   assign comp_bank       = comp_bank_q;
   assign bank_full       = bank_full_q;
   assign job_done        = job_done_q;

endmodule

// File: doc/feature_pingpong_ctrl.md
# feature_pingpong_ctrl

Write-side scheduler for the double-buffered feature memory. It accepts a job of N tiles, streams incoming feature words into whichever bank is free, and generates the per-word write enable, address and bank select consumed by the feature_load bank demux. It hands each filled bank to the compute side with a one-cycle start pulse and reclaims the bank on the compute side's done pulse, so filling one bank overlaps computation on the other.

## Interface
- FEATURE_WIDTH, 16, width of one feature element; one bus word carries 2 elements.
- ADDR_WIDTH, 15, bank word-address width.

- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- cfg_valid  in  1  job descriptor valid.
- cfg_ready  out  1  job descriptor can be accepted.
- cfg_tile_words  in  ADDR_WIDTH  words per tile; legal range 1..2^ADDR_WIDTH-1.
- cfg_num_tiles  in  8  tiles in the job; legal range 1..255.
- in_valid  in  1  input feature word valid.
- in_ready  out  1  controller accepts the input word.
- in_data  in  2*FEATURE_WIDTH  input feature word.
- fetcher_to_mem  out  1  registered write enable.
- wr_feature_addr  out  ADDR_WIDTH  registered write address.
- wr_feature_data  out  2*FEATURE_WIDTH  registered write data.
- wr_feature_sel  out  1  registered bank select: 0 = bank0, 1 = bank1.
- comp_start  out  1  one-cycle pulse: bank comp_bank is full and owned by compute.
- comp_bank  out  1  bank currently owned by compute.
- comp_done  in  1  one-cycle pulse: compute has released comp_bank.
- bank_full  out  2  per-bank full flag.
- job_done  out  1  one-cycle pulse when the last tile of the job is released.

## Operation
- Write FSM states:
  - W_IDLE: cfg_ready=1. On cfg_valid with both fields nonzero, latch tile_words and num_tiles, clear the word and tile counters, and go to W_FILL. A descriptor with either field zero is consumed and ignored; the FSM stays in W_IDLE. cfg_ready=0 in every other state.
  - W_FILL: in_ready=1. On each handshake (in_valid & in_ready), write in_data to bank wr_bank at address wcnt, then increment wcnt.
    - When the handshake has wcnt == tile_words-1: set bank_full[wr_bank], toggle wr_bank, clear wcnt, and increment tiles_written.
    - If that was the last tile, go to W_DRAIN.
    - Otherwise, if the new wr_bank is full and is not being released this cycle, go to W_WAIT; if not, stay in W_FILL.
  - W_WAIT: in_ready=0. When bank_full[wr_bank] clears (or comp_done releases it this cycle), go to W_FILL.
  - W_DRAIN: in_ready=0. When the read side releases the last tile, pulse job_done and go to W_IDLE.
- Read FSM states:
  - R_IDLE: when bank_full[rd_bank]=1, pulse comp_start with comp_bank=rd_bank and go to R_RUN.
  - R_RUN: on comp_done, clear bank_full[rd_bank], toggle rd_bank, increment tiles_read, and return to R_IDLE. comp_done while in R_IDLE is ignored.
- wr_bank and rd_bank reset to 0 and both toggle strictly alternately, so tiles are consumed in write order.
- Set and clear of the same bank never coincide: the fill bank is never full, and compute only owns a full bank. A release and a set on the other bank in the same cycle are both applied.
- Counters: wcnt is ADDR_WIDTH bits; tiles_written and tiles_read are 8 bits each. None of them wraps within a legal job.
- job_done fires on the comp_done that makes tiles_read == num_tiles.

## Timing
- Reset values: cfg_ready=1, in_ready=0, fetcher_to_mem=0, wr_feature_addr=0, wr_feature_data=0, wr_feature_sel=0, comp_start=0, comp_bank=0, bank_full=2'b00, job_done=0. Both FSMs reset to their IDLE states.
- Reset asserted mid-job aborts immediately: banks are marked empty and no pulse is emitted.
- Write latency: a handshake in cycle t produces fetcher_to_mem=1 with the matching addr, data and sel in cycle t+1. Sustained throughput is one word per cycle while a bank is free.
- The bank_full set is registered at the same edge as the last word's write, so bank_full becomes visible in cycle t+1.
- comp_start occurs no earlier than cycle t+2 after the last-word handshake at t. This guarantees the last word is written before compute starts.
- in_ready is a registered state decode; it does not depend combinationally on in_valid.
- W_WAIT exit: a comp_done in cycle t gives in_ready=1 in cycle t+1.
- The next comp_start comes no earlier than 1 cycle after the comp_done that released the previous bank.

## Test plan
- Basic job: tile_words=4, num_tiles=1, continuous in_valid.
  - Required: 4 writes to bank0 at addresses 0..3.
  - bank_full=01.
  - comp_start 2 cycles after the 4th handshake.
  - comp_done, then job_done the next cycle and cfg_ready=1.
- Ping-pong overlap: tile_words=8, num_tiles=4, compute holds each bank for 20 cycles.
  - Required: sel sequence 0,1,0,1.
  - in_ready drops while both banks are full.
  - in_ready=1 the cycle after each comp_done.
  - job_done after the 4th comp_done.
- Backpressure gaps: tile_words=5, in_valid toggling randomly.
  - Required: addresses 0..4 each written exactly once, with no address skipped.
- Same-cycle release: with bank1 full and owned by compute, comp_done coincides with the last-word handshake of bank0.
  - Required: the FSM stays in W_FILL writing bank1 at addr 0 next.
  - bank_full transitions 10 → 01.
- Illegal config: cfg_tile_words=0, then cfg_num_tiles=0.
  - Required: no writes, in_ready stays 0, cfg_ready stays 1.
- Reset mid-job: assert rst during the 3rd word of tile 2.
  - Required: all outputs return to reset values asynchronously.
  - A new job then starts at bank0, addr 0.
